mem_access_sequencer: RTL
=========================

// Module: mem_access_sequencer
// PURPOSE
//  MEM-stage consumer of the controller's R_Enable/W_Enable/R_Width/W_Width signals. It runs lw/lh/lb/sw/sh/sb
//  as byte-serial transfers on an 8-bit req/ack data-memory bus. Stall is held to the pipeline until the access
//  completes. It sign-extends lh/lb load data and flags misaligned and timed-out accesses.
// PARAMETERS
//  TIMEOUT   16   max cycles in XFER without MemAck before abort (>=2)
// PORTS
//  Clk        in   1   clock, rising edge
//  Reset      in   1   asynchronous, active-high reset
//  R_Enable   in   1   load request (MEM stage)
//  W_Enable   in   1   store request (MEM stage)
//  R_Width    in   2   0=word 1=half 2=byte 3=reserved
//  W_Width    in   2   same encoding as R_Width
//  Address    in   32  byte address from ALU
//  WriteData  in   32  store data (rt)
//  ReadData   out  32  load result, sign-extended for lh/lb
//  Stall      out  1   hold pipeline (combinational)
//  Done       out  1   1-cycle pulse, access finished
//  AddrErr    out  1   1-cycle pulse with Done: misaligned or reserved width
//  BusErr     out  1   1-cycle pulse with Done: ack timeout
//  MemReq     out  1   bus request, held until MemAck
//  MemWe      out  1   1=write byte, 0=read byte
//  MemAddr    out  32  byte address of current beat
//  MemWData   out  8   write byte
//  MemRData   in   8   read byte, valid when MemAck=1
//  MemAck     in   1   beat complete; ignored when MemReq=0
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0 (ReadData=0, MemReq=0, Stall=0). Reset mid-transfer drops MemReq at once.
//  States: IDLE, XFER, GAP, DONE.
//  IDLE: if R_Enable|W_Enable, latch Address/WriteData/width/dir, Stall=1, then go to XFER.
//   W_Enable has priority if both are high.
//   Beats: word=4, half=2, byte=1. Beat i has MemAddr=Address+i, little-endian, byte 0 first.
//   Misaligned (word Address[1:0]!=0, half Address[0]!=0) or width 3: go straight to DONE with AddrErr=1,
//   and MemReq never asserts.
//  XFER: MemReq=1, MemWe=dir, MemWData=WriteData[8i+7:8i].
//   On MemAck: loads capture MemRData into byte i of a shift reg.
//   Then go to DONE if this was the last beat, otherwise i++ and go to GAP.
//   A timeout counter clears on XFER entry and counts cycles without ack.
//   If it reaches TIMEOUT: go to DONE with BusErr=1 and ReadData unchanged.
//  GAP: MemReq=0 for exactly 1 cycle, then go to XFER (4-phase separation between beats).
//  DONE: Stall=0, Done=1. Loads update ReadData at the DONE clock edge:
//   word = {b3,b2,b1,b0}, half = {{16{b1[7]}},b1,b0}, byte = {{24{b0[7]}},b0}.
//   Request inputs in the DONE cycle are ignored. Next state is always IDLE.
//  Stall = (IDLE & (R_Enable|W_Enable)) | XFER | GAP.
//   The pipeline keeps the MEM-stage inputs stable while Stall=1.
//  Latency, zero-wait ack, accept at cycle 0: byte Done@2, half Done@4, word Done@8.
//   Each wait cycle adds 1.
//  ReadData holds its value across stores, errors and idle cycles. Stores never modify it.
//  MemAddr/MemWe/MemWData are don't-care while MemReq=0 and must be driven 0 in IDLE.
// TESTING
//  1 sw 0xDEADBEEF @0x10, zero-wait ack -> beats EF@10,BE@11,AD@12,DE@13; Done@cycle 8; Stall cycles 0-7.
//  2 lb @0x03, MemRData=0x80 -> ReadData=0xFFFFFF80, Done@2; then lh @0x02 with bytes 34,12 -> 0x00001234.
//  3 lh @0x01 -> AddrErr+Done@1, MemReq never 1, ReadData unchanged.
//  4 lw @0x20, MemAck never asserted -> BusErr+Done after TIMEOUT=16 XFER cycles, MemReq then 0.
//  5 lw with 2 wait cycles per beat, bytes 78,56,34,12 -> ReadData=0x12345678, Done@16; no ack accepted in GAP.
//  6 Reset asserted during beat 2 of sw -> MemReq/Stall 0 immediately, IDLE; next lb completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// MEM-stage load/store sequencer: runs word/half/byte accesses as byte-serial beats on an
// 8-bit req/ack bus, stalling the pipeline until done and sign-extending half/byte loads.
module mem_access_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk_i,
  input  logic        Reset_i,
  input  logic        R_Enable_i,
  input  logic        W_Enable_i,
  input  logic [1:0]  R_Width_i,
  input  logic [1:0]  W_Width_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        Stall_o,
  output logic        Done_o,
  output logic        AddrErr_o,
  output logic        BusErr_o,
  output logic        MemReq_o,
  output logic        MemWe_o,
  output logic [31:0] MemAddr_o,
  output logic [7:0]  MemWData_o,
  input  logic [7:0]  MemRData_i,
  input  logic        MemAck_i
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP, DONE} state_t;

  state_t        state_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    width_q;
  logic          write_q;
  logic [1:0]    beat_q;
  logic [TW-1:0] tmo_q;
  logic [31:0]   rbuf_q;
  logic [31:0]   read_data_q;
  logic          done_q;
  logic          addr_err_q;
  logic          bus_err_q;

  logic [1:0]    req_width;
  logic          misaligned;
  logic          last_beat;
  logic [31:0]   rbuf_d;
  logic [31:0]   load_result;

  // Store wins when both enables are high, so its width is the one that matters.
  always_comb begin
    req_width  = W_Enable_i ? W_Width_i : R_Width_i;
    misaligned = (req_width == 2'd3) ||
                 ((req_width == 2'd0) && (Address_i[1:0] != 2'b00)) ||
                 ((req_width == 2'd1) && Address_i[0]);
  end

  always_comb begin
    case (width_q)
      2'd0:    last_beat = (beat_q == 2'd3);
      2'd1:    last_beat = (beat_q == 2'd1);
      default: last_beat = 1'b1;
    endcase
  end

  // Buffer with the byte arriving this cycle merged in, so the final beat can
  // feed ReadData on the same edge that enters DONE.
  always_comb begin
    rbuf_d = rbuf_q;
    case (beat_q)
      2'd0: rbuf_d[7:0]   = MemRData_i;
      2'd1: rbuf_d[15:8]  = MemRData_i;
      2'd2: rbuf_d[23:16] = MemRData_i;
      2'd3: rbuf_d[31:24] = MemRData_i;
      default: rbuf_d = rbuf_q;
    endcase
  end

  always_comb begin
    case (width_q)
      2'd0:    load_result = rbuf_d;
      2'd1:    load_result = {{16{rbuf_d[15]}}, rbuf_d[15:0]};
      default: load_result = {{24{rbuf_d[7]}}, rbuf_d[7:0]};
    endcase
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      width_q     <= '0;
      write_q     <= 1'b0;
      beat_q      <= '0;
      tmo_q       <= '0;
      rbuf_q      <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (R_Enable_i || W_Enable_i) begin
            addr_q  <= Address_i;
            wdata_q <= WriteData_i;
            width_q <= req_width;
            write_q <= W_Enable_i;
            beat_q  <= '0;
            tmo_q   <= '0;
            if (misaligned) begin
              state_q    <= DONE;
              done_q     <= 1'b1;
              addr_err_q <= 1'b1;
            end else begin
              state_q <= XFER;
            end
          end
        end
        XFER: begin
          if (MemAck_i) begin
            tmo_q <= '0;
            if (!write_q) rbuf_q <= rbuf_d;
            if (last_beat) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              if (!write_q) read_data_q <= load_result;
            end else begin
              beat_q  <= beat_q + 2'd1;
              state_q <= GAP;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        GAP:     state_q <= XFER;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Stall_o    = ((state_q == IDLE) && (R_Enable_i || W_Enable_i)) ||
                      (state_q == XFER) || (state_q == GAP);
  assign Done_o     = done_q;
  assign AddrErr_o  = addr_err_q;
  assign BusErr_o   = bus_err_q;
  assign ReadData_o = read_data_q;
  assign MemReq_o   = (state_q == XFER);
  assign MemWe_o    = (state_q == XFER) && write_q;
  assign MemAddr_o  = (state_q == XFER) ? (addr_q + {30'd0, beat_q}) : 32'd0;
  assign MemWData_o = (state_q == XFER) ? 8'(wdata_q >> {beat_q, 3'b000}) : 8'd0;

endmodule
